// File: rtl/kernel_stream_sink.sv
// Kernel stream sink: packs PACK elements per wide word, buffers words in a show-ahead FIFO, flushes a padded tail word and raises done.
// Optional running checksum port enabled by defining KERNEL_STREAM_SINK_CHKSUM_EN.
module kernel_stream_sink #(
    parameter int STREAMW = 32,
    parameter int PACK    = 4,
    parameter int DEPTH   = 8,
    parameter int NELEMS  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      ivalid,
    output logic                      iready,
    input  logic [STREAMW-1:0]        in_s0,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [STREAMW*PACK-1:0]   wdata,
    output logic                      wlast,
    output logic                      done,
    output logic                      overflow
`ifdef KERNEL_STREAM_SINK_CHKSUM_EN
    ,
    output logic [STREAMW-1:0]        chksum
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CW = $clog2(NELEMS + 1);
    localparam int WW = STREAMW * PACK;

    localparam logic [AW:0]   FULL_C      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   RDY_MAX_C   = (AW+1)'(DEPTH - 2);
    localparam logic [IW-1:0] LAST_SLOT_C = IW'(PACK - 1);
    localparam logic [CW-1:0] LAST_ELEM_C = CW'(NELEMS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_r, state_n;
    logic [CW-1:0]     elem_r;
    logic [IW-1:0]     idx_r;
    logic [WW-1:0]     pack_r;
    logic [WW-1:0]     word_ins_s;
    logic [WW-1:0]     push_data_s;
    logic              push_s, push_last_s, pop_s, can_push_s;
    logic              accept_s, drop_s, clear_run_s;
    logic              iready_r, done_r, overflow_r;

    logic [WW-1:0]     mem_data_r [DEPTH];
    logic              mem_last_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [AW:0]       count_r, count_n;

    assign wvalid     = (count_r != {(AW+1){1'b0}});
    assign wdata      = wvalid ? mem_data_r[rd_ptr_r] : {WW{1'b0}};
    assign wlast      = wvalid ? mem_last_r[rd_ptr_r] : 1'b0;
    assign iready     = iready_r;
    assign done       = done_r;
    assign overflow   = overflow_r;
    assign pop_s      = wvalid & wready;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign can_push_s = (count_r != FULL_C) || pop_s;
    assign count_n    = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};

    // Current pack register with the incoming beat placed at the active slot.
    always_comb begin
        word_ins_s = pack_r;
        for (int i = 0; i < PACK; i++) begin
            if (idx_r == IW'(i)) begin
                word_ins_s[i*STREAMW +: STREAMW] = in_s0;
            end else begin
                word_ins_s[i*STREAMW +: STREAMW] = pack_r[i*STREAMW +: STREAMW];
            end
        end
    end

    // Next-state, beat accept/drop and FIFO push decisions.
    always_comb begin
        state_n     = state_r;
        push_s      = 1'b0;
        push_last_s = 1'b0;
        push_data_s = word_ins_s;
        accept_s    = 1'b0;
        drop_s      = 1'b0;
        clear_run_s = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n     = S_RUN;
                    clear_run_s = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            S_RUN: begin
                // Valid beats count even while iready is low: producers may lag ready.
                if (ivalid) begin
                    if (idx_r == LAST_SLOT_C) begin
                        if (can_push_s) begin
                            push_s      = 1'b1;
                            push_last_s = (elem_r == LAST_ELEM_C);
                            accept_s    = 1'b1;
                            state_n     = (elem_r == LAST_ELEM_C) ? S_DRAIN : S_RUN;
                        end else begin
                            drop_s = 1'b1;
                        end
                    end else begin
                        accept_s = 1'b1;
                        state_n  = (elem_r == LAST_ELEM_C) ? S_FLUSH : S_RUN;
                    end
                end else begin
                    state_n = S_RUN;
                end
            end
            S_FLUSH: begin
                if (can_push_s) begin
                    push_s      = 1'b1;
                    push_last_s = 1'b1;
                    push_data_s = pack_r;
                    state_n     = S_DRAIN;
                end else begin
                    state_n = S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (count_r == {(AW+1){1'b0}}) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_DRAIN;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Control state, element/slot counters, pack register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            elem_r     <= {CW{1'b0}};
            idx_r      <= {IW{1'b0}};
            pack_r     <= {WW{1'b0}};
            overflow_r <= 1'b0;
            iready_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r  <= state_n;
            iready_r <= (state_n == S_RUN) && (count_n <= RDY_MAX_C);
            done_r   <= (state_n == S_DONE);
            if (clear_run_s) begin
                elem_r     <= {CW{1'b0}};
                idx_r      <= {IW{1'b0}};
                pack_r     <= {WW{1'b0}};
                overflow_r <= 1'b0;
            end else if (accept_s) begin
                elem_r <= elem_r + CW'(1);
                if (idx_r == LAST_SLOT_C) begin
                    idx_r  <= {IW{1'b0}};
                    pack_r <= {WW{1'b0}};
                end else begin
                    idx_r  <= idx_r + IW'(1);
                    pack_r <= word_ins_s;
                end
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            count_r <= count_n;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // FIFO storage; stale contents are masked by wvalid so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r] <= push_data_s;
            mem_last_r[wr_ptr_r] <= push_last_s;
        end
    end

`ifdef KERNEL_STREAM_SINK_CHKSUM_EN
    logic [STREAMW-1:0] chksum_r;
    assign chksum = chksum_r;

    // Running sum of stored beats; dropped beats never reach accept_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            chksum_r <= {STREAMW{1'b0}};
        end else if (clear_run_s) begin
            chksum_r <= {STREAMW{1'b0}};
        end else if (accept_s) begin
            chksum_r <= chksum_r + in_s0;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_stream_sink.sv
// Self-checking bench for kernel_stream_sink: randomized runs against a queue-based reference model with a decoupled word scoreboard.
module tb_kernel_stream_sink;

    localparam int W      = 32;
    localparam int PACK   = 4;
    localparam int DEPTH  = 8;
    localparam int NELEMS = 42;
    localparam int WW     = W * PACK;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ivalid = 1'b0;
    logic          wready = 1'b0;
    logic [W-1:0]  in_s0 = '0;
    logic          iready, wvalid, wlast, done, overflow;
    logic [WW-1:0] wdata;
`ifdef KERNEL_STREAM_SINK_CHKSUM_EN
    logic [W-1:0]  chksum;
`endif

    kernel_stream_sink #(.STREAMW(W), .PACK(PACK), .DEPTH(DEPTH), .NELEMS(NELEMS)) dut (
        .clk(clk), .rst(rst), .start(start), .ivalid(ivalid), .iready(iready),
        .in_s0(in_s0), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wlast(wlast), .done(done), .overflow(overflow)
`ifdef KERNEL_STREAM_SINK_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [WW-1:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: phase flags, element tally, words in the writer's buffer.
    bit           m_idle = 1'b1, m_run = 1'b0, m_flush = 1'b0, m_drain = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    int           m_cnt = 0, m_nacc = 0;
    logic [W-1:0] m_cur[$];
    logic [W-1:0] m_sum = '0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_word(input bit last);
        logic [WW-1:0] w;
        ent_t e;
        w = '0;
        for (int i = 0; i < m_cur.size(); i++) w[i*W +: W] = m_cur[i];
        e.last = last;
        e.data = w;
        exp_q.push_back(e);
        m_cur.delete();
    endtask

    task automatic model_step();
        bit pop_m, push_m;
        if (rst) begin
            m_idle = 1'b1; m_run = 1'b0; m_flush = 1'b0; m_drain = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
            m_cnt = 0; m_nacc = 0; m_sum = '0;
            m_cur.delete();
            exp_q.delete();
            return;
        end
        pop_m  = (m_cnt > 0) && wready;
        push_m = 1'b0;
        if (start && (m_idle || m_done)) begin
            m_idle = 1'b0; m_done = 1'b0; m_run = 1'b1; m_ovf = 1'b0;
            m_nacc = 0; m_sum = '0;
            m_cur.delete();
        end else if (m_run) begin
            if (ivalid) begin
                if (m_cur.size() == PACK - 1) begin
                    if (m_cnt < DEPTH || pop_m) begin
                        m_cur.push_back(in_s0);
                        m_nacc++;
                        m_sum += in_s0;
                        push_word(m_nacc == NELEMS);
                        push_m = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else begin
                    m_cur.push_back(in_s0);
                    m_nacc++;
                    m_sum += in_s0;
                end
                if (m_nacc == NELEMS) begin
                    m_run = 1'b0;
                    if (m_cur.size() > 0) m_flush = 1'b1;
                    else m_drain = 1'b1;
                end
            end
        end else if (m_flush) begin
            if (m_cnt < DEPTH || pop_m) begin
                push_word(1'b1);
                push_m  = 1'b1;
                m_flush = 1'b0;
                m_drain = 1'b1;
            end
        end else if (m_drain) begin
            if (m_cnt == 0) begin
                m_drain = 1'b0;
                m_done  = 1'b1;
            end
        end
        m_cnt = m_cnt + int'(push_m) - int'(pop_m);
    endtask

    // One clock: model consumes the driven inputs, then DUT status is compared after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("iready", iready, m_run && (m_cnt <= DEPTH - 2));
        chk("wvalid", wvalid, m_cnt > 0);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
`ifdef KERNEL_STREAM_SINK_CHKSUM_EN
        chk("chksum", chksum, m_sum);
`endif
    endtask

    // Modes: 0 random, 1 one-cycle-lag producer, 2 flood with stalled writer, 3 sequence 1..N.
    task automatic run(input int mode, input int vpct, input int rpct);
        int           cyc;
        bit           prev_rdy;
        logic [W-1:0] seq;
        cyc = 0; prev_rdy = 1'b0; seq = 1;
        start = 1'b1; ivalid = 1'b0; wready = 1'b0;
        tick();
        start = 1'b0;
        while (!m_done && cyc < 3000) begin
            case (mode)
                0: begin
                    ivalid = ($urandom_range(99) < vpct);
                    wready = ($urandom_range(99) < rpct);
                    in_s0  = $urandom;
                    start  = ($urandom_range(99) < 3);
                end
                1: begin
                    ivalid   = prev_rdy;
                    prev_rdy = iready;
                    wready   = (cyc >= 60) ? ($urandom_range(99) < rpct) : 1'b0;
                    in_s0    = $urandom;
                end
                2: begin
                    ivalid = 1'b1;
                    wready = (cyc >= 70) ? ($urandom_range(99) < rpct) : 1'b0;
                    in_s0  = $urandom;
                end
                3: begin
                    ivalid = 1'b1;
                    wready = 1'b1;
                    in_s0  = seq;
                    seq    = seq + 1;
                end
                default: begin
                    ivalid = 1'b0;
                end
            endcase
            tick();
            cyc++;
        end
        start = 1'b0; ivalid = 1'b0;
        checks++;
        if (!m_done) begin
            failures++;
            $display("FAIL run_timeout: mode %0d got done=%0b expected 1 within 3000 cycles", mode, done);
        end
        chk("words_left", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && wvalid && wready) begin : pop_blk
            ent_t e;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %0h expected no word", wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wdata", wdata, e.data);
                chk("wlast", wlast, e.last);
            end
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_wdata", wdata, '0);
        chk("rst_wlast", wlast, 1'b0);
        rst = 1'b0;
        // Beats outside a run are ignored.
        for (int i = 0; i < 5; i++) begin
            ivalid = $urandom_range(1);
            in_s0  = $urandom;
            tick();
        end
        ivalid = 1'b0;

        run(3, 100, 100);
`ifdef KERNEL_STREAM_SINK_CHKSUM_EN
        chk("chksum_seq", chksum, (NELEMS * (NELEMS + 1)) / 2);
`endif
        run(0, 70, 60);
        run(2, 100, 50);
        chk("flood_overflow", overflow, 1'b1);
        run(1, 100, 70);
        chk("lag_no_overflow", overflow, 1'b0);
        run(0, 100, 100);

        // Reset in the middle of a run with three words buffered.
        start = 1'b1;
        tick();
        start = 1'b0; ivalid = 1'b1; wready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_s0 = $urandom;
            tick();
        end
        ivalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wlast", wlast, 1'b0);
        wready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        run(0, 50, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
